// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset/bubble encodings, instruction memory geometry
// and the address helpers used by the PC logic.
package fetch_stage_pkg;

  localparam int          IMEM_AW    = 6;
  localparam int          WORD_SHIFT = 2;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'h0000_0004;

  // Implicit per-cycle behaviour of the stage; decoded combinationally, never stored.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_FLUSH = 2'd2
  } fetch_mode_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:WORD_SHIFT], 2'b00};
  endfunction

  function automatic logic [IMEM_AW-1:0] word_index(input logic [31:0] addr);
    return addr[WORD_SHIFT +: IMEM_AW];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag with
// reset > flush > load > hold priority. Flush keeps pc4 as it was.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // Pipeline register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= NOP;
      pc4   <= 32'h0000_0000;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end else begin
      instr <= instr;
      pc4   <= pc4;
      valid <= valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, retired-fetch counter
// and the IF/ID register that latches the instruction memory output.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [31:0]        fetch_count
);

  fetch_mode_t mode;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] count_next;
  logic        load;
  logic        flush;

  assign pc_plus4  = pc + PC_STEP;
  assign imem_addr = word_index(pc);

  // Redirect outranks stall so a taken branch is never lost behind a decode hold.
  always_comb begin
    mode = MODE_RUN;
    if (branch_taken) begin
      mode = MODE_FLUSH;
    end else if (stall) begin
      mode = MODE_HOLD;
    end else begin
      mode = MODE_RUN;
    end
  end

  // Next PC, counter and IF/ID controls for the current mode.
  always_comb begin
    pc_next    = pc;
    count_next = fetch_count;
    load       = 1'b0;
    flush      = 1'b0;
    case (mode)
      MODE_RUN: begin
        pc_next    = pc_plus4;
        count_next = fetch_count + 32'd1;
        load       = 1'b1;
      end
      MODE_FLUSH: begin
        pc_next = align_word(branch_target);
        flush   = 1'b1;
      end
      MODE_HOLD: begin
        pc_next    = pc;
        count_next = fetch_count;
      end
      default: begin
        pc_next    = pc;
        count_next = fetch_count;
      end
    endcase
  end

  // PC and retired-fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_count <= 32'h0000_0000;
    end else begin
      pc          <= pc_next;
      fetch_count <= count_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (flush),
    .instr_in (imem_data),
    .pc4_in   (pc_plus4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 64-word instruction memory model
// (words 0-4 = 17, 9, 25, 55, 40; other words 0x1000 + index).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] inst_mem [64];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign imem_data = inst_mem[imem_addr];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".addr"}, {26'd0, imem_addr}, {26'd0, e_pc[7:2]});
    check({tag, ".instr"}, if_id_instr, e_instr);
    check({tag, ".pc4"}, if_id_pc4, e_pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check({tag, ".count"}, fetch_count, e_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] seq_instr [5];
    seq_instr[0] = 32'd17; seq_instr[1] = 32'd9; seq_instr[2] = 32'd25;
    seq_instr[3] = 32'd55; seq_instr[4] = 32'd40;
    for (int i = 0; i < 64; i++) inst_mem[i] = 32'h0000_1000 + 32'(i);
    for (int i = 0; i < 5; i++) inst_mem[i] = seq_instr[i];

    // Reset values
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    tick(); tick();
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0;

    // Free-running sequence
    for (int i = 0; i < 5; i++) begin
      tick();
      check("run.instr", if_id_instr, seq_instr[i]);
      check("run.pc4", if_id_pc4, 32'(4 * (i + 1)));
      check("run.valid", {31'd0, if_id_valid}, 32'd1);
    end
    check("run.count", fetch_count, 32'd5);
    check("run.pc", pc, 32'd20);

    // Stall for 3 cycles after word 1 is latched
    do_reset();
    tick();
    tick();
    check_state("prestall", 32'd8, 32'd9, 32'd8, 1'b1, 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state("stall", 32'd8, 32'd9, 32'd8, 1'b1, 32'd2);
    end
    stall = 1'b0;
    tick();
    check_state("unstall", 32'd12, 32'd25, 32'd12, 1'b1, 32'd3);

    // Branch to 12 while pc=4
    do_reset();
    tick();
    check("br.pre_pc", pc, 32'd4);
    branch_taken = 1'b1; branch_target = 32'd12;
    tick();
    check_state("br.bubble", 32'd12, 32'd0, 32'd4, 1'b0, 32'd1);
    branch_taken = 1'b0;
    tick();
    check_state("br.target", 32'd16, 32'd55, 32'd16, 1'b1, 32'd2);

    // Branch with stall, misaligned target 0x11
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h11;
    tick();
    check_state("brst.bubble", 32'h10, 32'd0, 32'd16, 1'b0, 32'd2);
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    check_state("brst.target", 32'h14, 32'd40, 32'h14, 1'b1, 32'd3);

    // Branch to 0xFC then wrap of the word index
    branch_taken = 1'b1; branch_target = 32'hFC;
    tick();
    check_state("wrap.br", 32'hFC, 32'd0, 32'h14, 1'b0, 32'd3);
    branch_taken = 1'b0;
    tick();
    check_state("wrap.1", 32'h100, 32'h0000_103F, 32'h100, 1'b1, 32'd4);
    tick();
    check_state("wrap.2", 32'h104, 32'd17, 32'h104, 1'b1, 32'd5);

    // 32-bit PC wrap from 0xFFFF_FFFC
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    check_state("pcwrap.br", 32'hFFFF_FFFC, 32'd0, 32'h104, 1'b0, 32'd5);
    branch_taken = 1'b0;
    tick();
    check_state("pcwrap.1", 32'h0, 32'h0000_103F, 32'h0, 1'b1, 32'd6);

    // Reset mid-stream (count 7) while stall and branch are also requested
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    check("mid.count", fetch_count, 32'd7);
    rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    check_state("mid.reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick();
    check_state("mid.first", 32'd4, 32'd17, 32'd4, 1'b1, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
